// File: rtl/temp_meas_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : temp_meas_if
// Purpose  : Groups the control, sensor and result-handshake signals of the
//            temperature measurement sequencer into one bundle.
// Ports    : start, continuous, abort, result_ack -- control requests
//            pulse                                -- sensor bitstream sample
//            sensor_en, busy                      -- sequencer status
//            result, result_valid, overrun        -- result handshake
// Modports : master -- control/consumer side (drives requests and pulse)
//            slave  -- sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface temp_meas_if #(
    parameter int RW = 11
);
    logic          start;
    logic          continuous;
    logic          abort;
    logic          pulse;
    logic          result_ack;
    logic          sensor_en;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          overrun;

    modport master (
        output start, continuous, abort, pulse, result_ack,
        input  sensor_en, busy, result, result_valid, overrun
    );

    modport slave (
        input  start, continuous, abort, pulse, result_ack,
        output sensor_en, busy, result, result_valid, overrun
    );
endinterface
`default_nettype wire

// File: rtl/temp_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : temp_meas_sequencer
// Purpose  : Enables the temperature sensor, waits a settling time, counts
//            '1' samples of the sensor bitstream over a fixed window and
//            presents the count through a valid/ack handshake. Supports
//            single-shot and continuous conversion.
// Ports    : clk    -- system clock, rising edge
//            rst_n  -- synchronous active-low reset
//            tm_if  -- temp_meas_if.slave bundle (requests, pulse, status,
//                      result handshake)
// Options  : TEMP_MEAS_AVG4_EN -- when defined, each reported result is the
//            truncated average of 4 back-to-back windows.
// Revision : 1.0 - initial release
// ============================================================================
module temp_meas_sequencer #(
    parameter int NUMBER_OF_SAMPLES = 2047,
    parameter int SETTLE_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    temp_meas_if.slave tm_if
);
    localparam int RW = $clog2(NUMBER_OF_SAMPLES + 1);
    localparam int SW = $clog2(NUMBER_OF_SAMPLES);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_COUNT  = 2'd2;

    localparam logic [SW-1:0] c_SMP_LAST   = SW'(NUMBER_OF_SAMPLES - 1);
    localparam logic [SW-1:0] c_SMP_ONE    = SW'(1);
    localparam logic [TW-1:0] c_SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] c_SETTLE_ONE  = TW'(1);
    localparam logic [RW-1:0] c_RW_ZERO    = '0;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] settle_cnt_q;
    logic [SW-1:0] sample_cnt_q;
    logic [RW-1:0] ones_q;
    logic [RW-1:0] result_q;
    logic          result_valid_q;
    logic          overrun_q;

    logic          w_settle_done;
    logic          w_last_sample;
    logic [RW-1:0] w_window;
    logic          w_group_end;
    logic [RW-1:0] w_new_result;
    logic          w_report;
    logic          w_start_acc;
    logic          w_sensor_en;
    logic          w_busy;

    assign w_settle_done = (settle_cnt_q == c_SETTLE_LAST);
    assign w_last_sample = (sample_cnt_q == c_SMP_LAST);
    // Count including the current sample; cannot exceed NUMBER_OF_SAMPLES.
    assign w_window      = ones_q + {c_RW_ZERO[RW-1:1], tm_if.pulse};
    assign w_start_acc   = (state_q == c_IDLE) && tm_if.start;
    // abort outranks a window completing in the same cycle.
    assign w_report      = (state_q == c_COUNT) && !tm_if.abort &&
                           w_last_sample && w_group_end;

`ifdef TEMP_MEAS_AVG4_EN
    logic [RW+1:0] acc_q;
    logic [1:0]    win_cnt_q;
    logic [RW+1:0] w_sum;

    assign w_sum        = acc_q + {2'b00, w_window};
    assign w_group_end  = (win_cnt_q == 2'd3);
    assign w_new_result = w_sum[RW+1:2];

    // Accumulates window counts of a group of 4; any exit from COUNT
    // (abort, completion without continuous) discards the partial group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            win_cnt_q <= 2'd0;
        end else if ((state_q != c_COUNT) || tm_if.abort) begin
            acc_q     <= '0;
            win_cnt_q <= 2'd0;
        end else if (w_last_sample) begin
            if (w_group_end) begin
                acc_q     <= '0;
                win_cnt_q <= 2'd0;
            end else begin
                acc_q     <= w_sum;
                win_cnt_q <= win_cnt_q + 2'd1;
            end
        end
    end
`else
    assign w_group_end  = 1'b1;
    assign w_new_result = w_window;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (tm_if.start) begin
                    state_d = c_SETTLE;
                end
            end
            c_SETTLE: begin
                if (tm_if.abort) begin
                    state_d = c_IDLE;
                end else if (w_settle_done) begin
                    state_d = c_COUNT;
                end
            end
            c_COUNT: begin
                // continuous keeps the sensor running into the next window
                // without re-settling.
                if (tm_if.abort) begin
                    state_d = c_IDLE;
                end else if (w_last_sample && w_group_end && !tm_if.continuous) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_sensor_en = 1'b0;
        w_busy      = 1'b0;
        case (state_q)
            c_SETTLE, c_COUNT: begin
                w_sensor_en = 1'b1;
                w_busy      = 1'b1;
            end
            default: begin
                w_sensor_en = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Settle / sample counters. Counters clear whenever they do not
    // advance, which covers every entry into SETTLE and COUNT as well as
    // the back-to-back window restart in continuous mode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ones_q       <= '0;
        end else begin
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ones_q       <= '0;
            if ((state_q == c_SETTLE) && !tm_if.abort && !w_settle_done) begin
                settle_cnt_q <= settle_cnt_q + c_SETTLE_ONE;
            end
            if ((state_q == c_COUNT) && !tm_if.abort && !w_last_sample) begin
                sample_cnt_q <= sample_cnt_q + c_SMP_ONE;
                ones_q       <= w_window;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result handshake. A report in the same cycle as an accepted ack
    // keeps result_valid high with the new value and no overrun.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (result_valid_q && tm_if.result_ack) begin
                result_valid_q <= 1'b0;
            end
            if (w_report) begin
                result_q       <= w_new_result;
                result_valid_q <= 1'b1;
                if (result_valid_q && !tm_if.result_ack) begin
                    overrun_q <= 1'b1;
                end
            end
            if (w_start_acc) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign tm_if.sensor_en    = w_sensor_en;
    assign tm_if.busy         = w_busy;
    assign tm_if.result       = result_q;
    assign tm_if.result_valid = result_valid_q;
    assign tm_if.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_meas_sequencer
// Purpose  : Self-checking bench for temp_meas_sequencer with
//            NUMBER_OF_SAMPLES=7, SETTLE_CYCLES=3. Stimulus pushes expected
//            results into a scoreboard queue; a monitor pops and compares
//            whenever the DUT presents a new result.
// Options  : TEMP_MEAS_AVG4_EN selects the 4-window averaging scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_meas_sequencer;
    localparam int NS = 7;
    localparam int SS = 3;
    localparam int RW = $clog2(NS + 1);

    typedef struct packed {
        logic [RW-1:0] res;
        logic          ovr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    temp_meas_if #(.RW(RW)) tm_if ();

    temp_meas_sequencer #(
        .NUMBER_OF_SAMPLES(NS),
        .SETTLE_CYCLES    (SS)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tm_if(tm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int res, input logic ovr);
        exp_t e;
        e.res = RW'(res);
        e.ovr = ovr;
        sb.push_back(e);
    endtask

    // Start sampled at edge 1, then SETTLE occupies edges 2..SS+1.
    task automatic start_settle(input logic settle_val);
        tm_if.start = 1'b1;
        tm_if.pulse = settle_val;
        tick();
        tm_if.start = 1'b0;
        check("sensor_en_on", tm_if.sensor_en, 1);
        check("busy_on", tm_if.busy, 1);
        repeat (SS) begin
            tm_if.pulse = settle_val;
            tick();
        end
    endtask

    task automatic window(input logic [NS-1:0] pat, input logic ack_last,
                          input logic start_mid);
        for (int i = 0; i < NS; i++) begin
            tm_if.pulse      = pat[i];
            tm_if.result_ack = (i == NS - 1) ? ack_last : 1'b0;
            tm_if.start      = (i == 2) ? start_mid : 1'b0;
            tick();
        end
        tm_if.result_ack = 1'b0;
        tm_if.start      = 1'b0;
        tm_if.pulse      = 1'b0;
    endtask

    task automatic ack();
        tm_if.result_ack = 1'b1;
        tick();
        tm_if.result_ack = 1'b0;
        check("valid_after_ack", tm_if.result_valid, 0);
    endtask

    // Monitor: a new result is presented when valid rises, when valid stays
    // high after an accepted ack, or when the value changes while valid.
    logic          prev_valid;
    logic          prev_taken;
    logic [RW-1:0] prev_result;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  <= 1'b0;
            prev_taken  <= 1'b0;
            prev_result <= '0;
        end else begin
            if (tm_if.result_valid &&
                (!prev_valid || prev_taken || (tm_if.result != prev_result))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", tm_if.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_result", tm_if.result, e.res);
                    check("sb_overrun", tm_if.overrun, e.ovr);
                end
            end
            prev_valid  <= tm_if.result_valid;
            prev_taken  <= tm_if.result_valid && tm_if.result_ack;
            prev_result <= tm_if.result;
        end
    end

    initial begin
        rst_n            = 1'b0;
        tm_if.start      = 1'b0;
        tm_if.continuous = 1'b0;
        tm_if.abort      = 1'b0;
        tm_if.pulse      = 1'b0;
        tm_if.result_ack = 1'b0;
        repeat (2) tick();
        check("rst_sensor_en", tm_if.sensor_en, 0);
        check("rst_busy", tm_if.busy, 0);
        check("rst_result", tm_if.result, 0);
        check("rst_valid", tm_if.result_valid, 0);
        check("rst_overrun", tm_if.overrun, 0);
        rst_n = 1'b1;
        tick();

`ifdef TEMP_MEAS_AVG4_EN
        // Windows of 7,6,5,4 ones: 22 >> 2 = 5.
        push(5, 1'b0);
        start_settle(1'b0);
        window(7'b1111111, 1'b0, 1'b0);
        check("avg_no_valid_w1", tm_if.result_valid, 0);
        window(7'b0111111, 1'b0, 1'b0);
        window(7'b0011111, 1'b0, 1'b0);
        window(7'b0001111, 1'b0, 1'b0);
        check("avg_valid", tm_if.result_valid, 1);
        check("avg_idle", tm_if.busy, 0);
        ack();
`else
        // Single shot, pulse=1: result 7 valid 11 edges after start.
        push(7, 1'b0);
        start_settle(1'b1);
        repeat (NS - 1) begin
            tm_if.pulse = 1'b1;
            tick();
        end
        check("lat_valid_early", tm_if.result_valid, 0);
        tick();
        check("lat_valid", tm_if.result_valid, 1);
        check("single_sensor_off", tm_if.sensor_en, 0);
        check("single_idle", tm_if.busy, 0);
        tm_if.pulse = 1'b0;
        ack();

        // Alternating 1,0 -> 4; a start mid-window is ignored.
        push(4, 1'b0);
        start_settle(1'b0);
        window(7'b1010101, 1'b0, 1'b1);
        ack();
        repeat (5) tick();
        check("start_busy_ignored", tm_if.busy, 0);

        // Pulses only during SETTLE are not counted.
        push(0, 1'b0);
        start_settle(1'b1);
        window(7'b0000000, 1'b0, 1'b0);
        ack();

        // Continuous, no ack: 7 then 0 with overrun.
        push(7, 1'b0);
        push(0, 1'b1);
        tm_if.continuous = 1'b1;
        start_settle(1'b1);
        window(7'b1111111, 1'b0, 1'b0);
        check("cont_busy", tm_if.busy, 1);
        tm_if.continuous = 1'b0;
        window(7'b0000000, 1'b0, 1'b0);
        check("ovr_flag", tm_if.overrun, 1);
        check("ovr_valid", tm_if.result_valid, 1);
        check("ovr_idle", tm_if.busy, 0);
        ack();
        check("ovr_sticky", tm_if.overrun, 1);

        // Continuous, ack coincides with second completion: no overrun.
        push(7, 1'b0);
        push(5, 1'b0);
        tm_if.continuous = 1'b1;
        start_settle(1'b1);
        check("ovr_cleared_by_start", tm_if.overrun, 0);
        window(7'b1111111, 1'b0, 1'b0);
        tm_if.continuous = 1'b0;
        window(7'b0011111, 1'b1, 1'b0);
        check("ackcoinc_overrun", tm_if.overrun, 0);
        check("ackcoinc_valid", tm_if.result_valid, 1);

        // Abort at the 4th COUNT cycle with a prior result of 5 pending.
        start_settle(1'b1);
        tm_if.pulse = 1'b1;
        tick();
        tm_if.start = 1'b1;
        tick();
        tm_if.start = 1'b0;
        tick();
        tm_if.abort = 1'b1;
        tick();
        tm_if.abort = 1'b0;
        tm_if.pulse = 1'b0;
        check("abort_busy", tm_if.busy, 0);
        check("abort_sensor_en", tm_if.sensor_en, 0);
        check("abort_result", tm_if.result, 5);
        check("abort_valid", tm_if.result_valid, 1);
        repeat (12) tick();
        check("abort_stays_idle", tm_if.busy, 0);
        check("abort_result_hold", tm_if.result, 5);

        // Reset mid-COUNT while a result is valid.
        start_settle(1'b1);
        tm_if.pulse = 1'b1;
        repeat (3) tick();
        check("midcount_busy", tm_if.busy, 1);
        rst_n = 1'b0;
        tick();
        check("rst2_sensor_en", tm_if.sensor_en, 0);
        check("rst2_busy", tm_if.busy, 0);
        check("rst2_result", tm_if.result, 0);
        check("rst2_valid", tm_if.result_valid, 0);
        check("rst2_overrun", tm_if.overrun, 0);
        rst_n       = 1'b1;
        tm_if.pulse = 1'b0;
        tick();
`endif

        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/temp_meas_sequencer.md
Name: temp_meas_sequencer

Overview:
- Measurement controller for the temperature-sensor bitstream path.
- On request it enables the sensor and waits a settling time.
- It then counts '1' samples of the sensor pulse stream over a fixed window and presents the count with a valid/ack handshake.
- Supports single-shot and continuous conversion; sits between the digital control interface and the analog sensor front end.

Parameters:
- NUMBER_OF_SAMPLES, 2047, window length in clock cycles (>=2).
- SETTLE_CYCLES, 64, cycles between sensor_en rising and first counted sample (>=1).
- RW (localparam), $clog2(NUMBER_OF_SAMPLES+1), result width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a conversion; ignored unless IDLE.
- continuous  input  1  sampled at each window end; 1 = start next conversion immediately.
- abort  input  1  return to IDLE at next edge, discard partial window.
- pulse  input  1  sensor bitstream sample, one per clk.
- sensor_en  output  1  analog sensor enable.
- busy  output  1  high in any state except IDLE.
- result  output  RW  count of pulse==1 in last completed window.
- result_valid  output  1  result holds an unacknowledged value.
- result_ack  input  1  consumer accepts result when result_valid && result_ack.
- overrun  output  1  sticky: a new result overwrote an unacknowledged one.

Behaviour:
- Reset (rst_n==0 at edge): state=IDLE; sensor_en=0, busy=0, result=0, result_valid=0, overrun=0; internal counters=0. Reset wins over all other inputs.
- States: IDLE, SETTLE, COUNT.
  - IDLE: start=1 -> SETTLE; sensor_en=1 and busy=1 from the next cycle.
  - SETTLE: settle counter runs 0..SETTLE_CYCLES-1; pulse is ignored. At SETTLE_CYCLES-1 -> COUNT with sample counter=0 and ones=0.
  - COUNT: every cycle ones += pulse and sample counter += 1. The cycle with sample counter==NUMBER_OF_SAMPLES-1 is the last counted sample.
- End of window:
  - result <= ones + pulse, so exactly NUMBER_OF_SAMPLES samples are included.
  - result_valid <= 1.
  - If continuous==1: stay in COUNT, counters cleared, no re-settle, sensor_en stays 1. The next window starts on the following cycle with no gap.
  - Else -> IDLE, sensor_en=0.
- Latency: single shot from start edge to result_valid = 1 + SETTLE_CYCLES + NUMBER_OF_SAMPLES cycles.
- Handshake:
  - result_valid stays high until the cycle after result_valid && result_ack.
  - result is stable while result_valid is high, except on overrun.
  - If a window completes while result_valid=1 and result_ack=0: result is overwritten, result_valid stays 1, overrun <= 1.
  - If a window completes in the same cycle as an accepted ack: the new result loads, result_valid stays 1, no overrun.
- overrun clears only on reset or on a start accepted in IDLE.
- abort in SETTLE or COUNT: -> IDLE next cycle, sensor_en=0. result and result_valid are untouched; no partial result is written. abort has priority over window completion in the same cycle. abort in IDLE has no effect.
- start while busy: ignored.
- continuous is only sampled at window end; changing it mid-window has no effect until then.
- Width rules:
  - ones is RW bits and cannot overflow (max NUMBER_OF_SAMPLES).
  - Sample counter is $clog2(NUMBER_OF_SAMPLES) bits and wraps via compare, not natural overflow.
  - Settle counter is $clog2(SETTLE_CYCLES+1) bits.

Optional Feature:
- Macro TEMP_MEAS_AVG4_EN.
- Defined:
  - Each reported result is the average of 4 consecutive back-to-back windows. The 4 window counts are accumulated in an RW+2-bit register and result = accumulated_sum >> 2 (truncating).
  - result_valid asserts only after the 4th window; latency is 1 + SETTLE_CYCLES + 4*NUMBER_OF_SAMPLES.
  - abort discards the partial accumulation. continuous repeats in groups of 4.
- Undefined: one window per result, as above; no accumulator logic is synthesized.

Test Plan:
- NUMBER_OF_SAMPLES=7, SETTLE_CYCLES=3, pulse=1 constantly, start pulse -> sensor_en high 1 cycle after start; result=7 with result_valid high 11 cycles after the start edge; sensor_en=0 afterwards.
- Same params, pulse alternating 1,0 starting with 1 at first counted sample -> result=4; pulses driven high during SETTLE are not counted (force pulse=1 only in SETTLE -> result=0).
- continuous=1, no ack, two windows with pulse=1 then pulse=0 -> first result=7, then result=0 with overrun=1 and result_valid=1. Ack with the second completion in the same cycle -> overrun stays 0.
- abort asserted at the 4th COUNT cycle after a prior result of 5 -> IDLE next cycle, sensor_en=0, result stays 5; start during busy produces no second conversion.
- rst_n=0 mid-COUNT with result_valid=1 -> next cycle all outputs 0 and state IDLE. With TEMP_MEAS_AVG4_EN and window counts 7,6,5,4 -> result=5 (22>>2).
